// File: rtl/mc_ctrl_wait.sv
// mc_ctrl_wait: multicycle control FSM with a variable-latency memory
// handshake, wait timeout, sticky halt/fault flags and a retired counter.
module mc_ctrl_wait #(
   parameter int IW       = 16,
   parameter int MAX_WAIT = 15,
   parameter int CNTW     = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [IW-1:0]   instr,
   input  logic            dcond,
   input  logic            mem_ready,
   output logic [4:0]      state,
   output logic [2:0]      fsel,
   output logic [3:0]      dsel,
   output logic            readReg,
   output logic            writeReg,
   output logic            readMem,
   output logic            writeMem,
   output logic            mem_req,
   output logic            ir_load,
   output logic            pc_inc,
   output logic            pc_load,
   output logic            halted,
   output logic            fault,
   output logic [CNTW-1:0] retired
);

   localparam logic [4:0] S_IDLE   = 5'd0;
   localparam logic [4:0] S_FETCH  = 5'd1;
   localparam logic [4:0] S_DECODE = 5'd2;
   localparam logic [4:0] S_EXEC   = 5'd3;
   localparam logic [4:0] S_MEM    = 5'd4;
   localparam logic [4:0] S_BRANCH = 5'd5;
   localparam logic [4:0] S_WB     = 5'd6;
   localparam logic [4:0] S_RETIRE = 5'd7;
   localparam logic [4:0] S_HALT   = 5'd8;
   localparam logic [4:0] S_FAULT  = 5'd9;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOAD  = 4'h8;
   localparam logic [3:0] OP_STORE = 4'h9;
   localparam logic [3:0] OP_BEQZ  = 4'hA;
   localparam logic [3:0] OP_JMP   = 4'hB;
   localparam logic [3:0] OP_LDI   = 4'hC;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   logic [4:0] cur_state;
   logic [4:0] next_state;
   logic [7:0] wait_cnt;
   logic [3:0] op;
   logic       is_alu;
   logic       timeout;
   logic       entering_req;
   logic       unused_operand;

   assign op             = instr[IW-1 -: 4];
   assign unused_operand = ^instr[IW-5:0];
   assign is_alu         = (op >= 4'h1) && (op <= 4'h7);
   assign state          = cur_state;

   // The count has already reached the limit and memory is still not ready;
   // a ready on that same cycle takes precedence over the timeout.
   assign timeout = (wait_cnt == WAIT_LIMIT) && !mem_ready;

   assign entering_req = ((next_state == S_FETCH) && (cur_state != S_FETCH)) ||
                         ((next_state == S_MEM)   && (cur_state != S_MEM));

   // Next-state selection from the current state, opcode and handshake
   always_comb begin
      next_state = cur_state;
      case (cur_state)
         S_IDLE:   next_state = S_FETCH;
         S_FETCH: begin
            if (mem_ready)
               next_state = S_DECODE;
            else if (timeout)
               next_state = S_FAULT;
         end
         S_DECODE: begin
            if (op == OP_NOP)
               next_state = S_RETIRE;
            else if (is_alu)
               next_state = S_EXEC;
            else if ((op == OP_LOAD) || (op == OP_STORE))
               next_state = S_MEM;
            else if (op == OP_BEQZ)
               next_state = S_BRANCH;
            else if (op == OP_JMP)
               next_state = S_RETIRE;
            else if (op == OP_LDI)
               next_state = S_WB;
            else if (op == OP_HALT)
               next_state = S_HALT;
            else
               next_state = S_FAULT;
         end
         S_EXEC:   next_state = S_WB;
         S_MEM: begin
            if (mem_ready)
               next_state = (op == OP_LOAD) ? S_WB : S_RETIRE;
            else if (timeout)
               next_state = S_FAULT;
         end
         S_BRANCH: next_state = S_RETIRE;
         S_WB:     next_state = S_RETIRE;
         S_RETIRE: next_state = S_FETCH;
         S_HALT:   next_state = S_HALT;
         S_FAULT:  next_state = S_FAULT;
         default:  next_state = S_FAULT;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset)
         cur_state <= S_IDLE;
      else
         cur_state <= next_state;
   end

   // Wait counter: restarts with each new request, counts unanswered cycles
   always_ff @(posedge clk) begin
      if (!reset)
         wait_cnt <= 8'd0;
      else if (entering_req)
         wait_cnt <= 8'd0;
      else if (mem_req && !mem_ready && !timeout)
         wait_cnt <= wait_cnt + 8'd1;
   end

   // Retired counter and sticky halt/fault flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         retired <= '0;
         halted  <= 1'b0;
         fault   <= 1'b0;
      end else begin
         if (cur_state == S_RETIRE)
            retired <= retired + 1'b1;
         if (next_state == S_HALT)
            halted <= 1'b1;
         if (next_state == S_FAULT)
            fault <= 1'b1;
      end
   end

   // Datapath controls decoded from the state; ir_load/pc_inc and the branch
   // pc_load also look at the handshake or condition within that state
   always_comb begin
      fsel     = 3'd0;
      dsel     = 4'b0000;
      readReg  = 1'b0;
      writeReg = 1'b0;
      readMem  = 1'b0;
      writeMem = 1'b0;
      mem_req  = 1'b0;
      ir_load  = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      case (cur_state)
         S_FETCH: begin
            mem_req = 1'b1;
            readMem = 1'b1;
            dsel    = 4'b0001;
            ir_load = mem_ready;
            pc_inc  = mem_ready;
         end
         S_DECODE: begin
            readReg = 1'b1;
            pc_load = (op == OP_JMP);
         end
         S_EXEC: begin
            readReg = 1'b1;
            fsel    = 3'(op - 4'd1);
         end
         S_MEM: begin
            mem_req = 1'b1;
            if (op == OP_LOAD)
               readMem = 1'b1;
            else
               writeMem = 1'b1;
         end
         S_BRANCH: pc_load = dcond;
         S_WB: begin
            writeReg = 1'b1;
            if (is_alu) begin
               dsel = 4'b0010;
               fsel = 3'(op - 4'd1);
            end else if (op == OP_LOAD)
               dsel = 4'b0100;
            else
               dsel = 4'b1000;
         end
         default: ;
      endcase
   end

endmodule
